// File: rtl/shifters_16bit.sv
// 16-bit bidirectional barrel rotator with a registered output.
// Holds a case-decoded and a log-stage rotator; IMPL picks which one feeds the register.
module shifters_16bit #(
  parameter int unsigned IMPL = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [3:0]  amt,
  input  logic        choice,
  output logic [15:0] y
);

  logic [15:0] w_case_r;
  logic [15:0] w_case_l;
  logic [15:0] w_case;
  logic [15:0] w_pre;
  logic [15:0] w_s1;
  logic [15:0] w_s2;
  logic [15:0] w_s4;
  logic [15:0] w_s8;
  logic [15:0] w_stage;
  logic [15:0] w_sel;
  logic [15:0] r_y;

  always_comb begin
    w_case_r = a;
    unique case (amt)
      4'd0:  w_case_r = a;
      4'd1:  w_case_r = {a[0],    a[15:1]};
      4'd2:  w_case_r = {a[1:0],  a[15:2]};
      4'd3:  w_case_r = {a[2:0],  a[15:3]};
      4'd4:  w_case_r = {a[3:0],  a[15:4]};
      4'd5:  w_case_r = {a[4:0],  a[15:5]};
      4'd6:  w_case_r = {a[5:0],  a[15:6]};
      4'd7:  w_case_r = {a[6:0],  a[15:7]};
      4'd8:  w_case_r = {a[7:0],  a[15:8]};
      4'd9:  w_case_r = {a[8:0],  a[15:9]};
      4'd10: w_case_r = {a[9:0],  a[15:10]};
      4'd11: w_case_r = {a[10:0], a[15:11]};
      4'd12: w_case_r = {a[11:0], a[15:12]};
      4'd13: w_case_r = {a[12:0], a[15:13]};
      4'd14: w_case_r = {a[13:0], a[15:14]};
      4'd15: w_case_r = {a[14:0], a[15]};
      default: w_case_r = a;
    endcase
  end

  always_comb begin
    w_case_l = a;
    unique case (amt)
      4'd0:  w_case_l = a;
      4'd1:  w_case_l = {a[14:0], a[15]};
      4'd2:  w_case_l = {a[13:0], a[15:14]};
      4'd3:  w_case_l = {a[12:0], a[15:13]};
      4'd4:  w_case_l = {a[11:0], a[15:12]};
      4'd5:  w_case_l = {a[10:0], a[15:11]};
      4'd6:  w_case_l = {a[9:0],  a[15:10]};
      4'd7:  w_case_l = {a[8:0],  a[15:9]};
      4'd8:  w_case_l = {a[7:0],  a[15:8]};
      4'd9:  w_case_l = {a[6:0],  a[15:7]};
      4'd10: w_case_l = {a[5:0],  a[15:6]};
      4'd11: w_case_l = {a[4:0],  a[15:5]};
      4'd12: w_case_l = {a[3:0],  a[15:4]};
      4'd13: w_case_l = {a[2:0],  a[15:3]};
      4'd14: w_case_l = {a[1:0],  a[15:2]};
      4'd15: w_case_l = {a[0],    a[15:1]};
      default: w_case_l = a;
    endcase
  end

  assign w_case = choice ? w_case_l : w_case_r;

  // Left rotate is done as reverse -> rotate right -> reverse.
  always_comb begin
    w_pre = a;
    for (int i = 0; i < 16; i++) begin
      w_pre[i] = choice ? a[15-i] : a[i];
    end
  end

  assign w_s1 = amt[0] ? {w_pre[0],   w_pre[15:1]} : w_pre;
  assign w_s2 = amt[1] ? {w_s1[1:0],  w_s1[15:2]}  : w_s1;
  assign w_s4 = amt[2] ? {w_s2[3:0],  w_s2[15:4]}  : w_s2;
  assign w_s8 = amt[3] ? {w_s4[7:0],  w_s4[15:8]}  : w_s4;

  always_comb begin
    w_stage = w_s8;
    for (int i = 0; i < 16; i++) begin
      w_stage[i] = choice ? w_s8[15-i] : w_s8[i];
    end
  end

  assign w_sel = (IMPL == 0) ? w_stage : w_case;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y <= 16'h0000;
    end else begin
      r_y <= w_sel;
    end
  end

  assign y = r_y;

endmodule

// File: tb/tb_shifters_16bit.sv
// Bench for shifters_16bit: both implementations side by side against an arithmetic rotate
// model with one-cycle latency, plus hand-computed directed expectations.
module tb_shifters_16bit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] a = 16'h0000;
  logic [3:0]  amt = 4'd0;
  logic        choice = 1'b0;
  logic [15:0] y0;
  logic [15:0] y1;
  logic [15:0] exp_y;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  shifters_16bit #(.IMPL(0)) u_dut0 (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .amt    (amt),
    .choice (choice),
    .y      (y0)
  );

  shifters_16bit #(.IMPL(1)) u_dut1 (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .amt    (amt),
    .choice (choice),
    .y      (y1)
  );

  function automatic logic [15:0] rot_model(input logic [15:0] d, input logic [3:0] n,
                                            input logic left);
    int unsigned v;
    int unsigned s;
    v = d;
    s = n;
    if (left) v = (v << s) | (v >> (16 - s));
    else      v = (v >> s) | (v << (16 - s));
    return v[15:0];
  endfunction

  // Reference register: clears on reset, otherwise holds last edge's rotate.
  always @(posedge clk or posedge reset) begin
    if (reset) exp_y <= 16'h0000;
    else       exp_y <= rot_model(a, amt, choice);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (a=%h amt=%0d choice=%0b)",
               nm, act, req, a, amt, choice);
    end
  endtask

  always @(negedge clk) begin
    chk("impl0_vs_model", y0, exp_y);
    chk("impl1_vs_model", y1, exp_y);
  end

  task automatic step(input logic [15:0] d, input logic [3:0] n, input logic left);
    @(negedge clk);
    a = d;
    amt = n;
    choice = left;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [15:0] req);
    chk({nm, "_impl0"}, y0, req);
    chk({nm, "_impl1"}, y1, req);
    chk({nm, "_model"}, exp_y, req);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    lit("reset_initial", 16'h0000);

    // Release, load something nonzero, then assert reset between edges.
    @(negedge clk);
    reset = 1'b0;
    step(16'h1234, 4'd0, 1'b0);
    lit("pre_async", 16'h1234);
    @(negedge clk);
    #2;
    a = 16'hFFFF;
    reset = 1'b1;
    #1;
    lit("async_reset", 16'h0000);

    @(negedge clk);
    a = 16'hFFFF;
    amt = 4'($urandom_range(15));
    choice = 1'($urandom_range(1));
    reset = 1'b0;
    @(posedge clk);
    #1;
    lit("first_after_reset", 16'hFFFF);

    for (int k = 1; k < 16; k++) begin
      step(16'hF3FF, 4'(k), 1'b1);
      if (k == 1)  lit("left_sweep_1", 16'hE7FF);
      if (k == 4)  lit("left_sweep_4", 16'h3FFF);
      if (k == 15) lit("left_sweep_15", 16'hF9FF);
    end

    step(16'h0001, 4'd1, 1'b0);  lit("right_bit_1", 16'h8000);
    step(16'h0001, 4'd4, 1'b0);  lit("right_bit_4", 16'h1000);
    step(16'h0001, 4'd11, 1'b0); lit("right_bit_11", 16'h0020);
    step(16'h0001, 4'd3, 1'b1);  lit("left_bit_3", 16'h0008);
    step(16'h0001, 4'd12, 1'b1); lit("left_bit_12", 16'h1000);
    step(16'h0001, 4'd15, 1'b1); lit("left_bit_15", 16'h8000);
    step(16'h8001, 4'd0, 1'b0);  lit("zero_right", 16'h8001);
    step(16'h8001, 4'd0, 1'b1);  lit("zero_left", 16'h8001);
    step(16'h8001, 4'd1, 1'b0);  lit("switch_right", 16'hC000);
    step(16'h8001, 4'd1, 1'b1);  lit("switch_left", 16'h0003);

    // Exhaustive amt x direction with random data; the negedge compare checks every cycle.
    for (int n = 0; n < 16; n++) begin
      for (int c = 0; c < 2; c++) begin
        for (int r = 0; r < 1000; r++) begin
          step(16'($urandom), 4'(n), 1'(c));
        end
      end
    end

    // Mid-stream reset discards the pending result.
    step(16'hA5A5, 4'd3, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    lit("midstream_reset", 16'h0000);
    @(posedge clk);
    #1;
    lit("reset_held", 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    step(16'h00F0, 4'd4, 1'b0);
    lit("after_midstream", 16'h000F);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
